muldiv_unit: RTL
================

// Module: muldiv_unit
//
// PURPOSE
//  Iterative multiply/divide unit that produces the HI/LO results for
//  MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//  - Sits beside the ALU in the EX stage of the pipelined core.
//  - Takes forwarded operands and stalls the front end through `busy`.
//  - Keeps HI/LO architectural state; the core reads it with MFHI/MFLO.
//  - Generalises the single-cycle ALU datapath to configurable width and to multi-cycle operation.
//
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH bits each; must be even and >= 4
//
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        synchronous, active-high
//  start        in   1        request a new op; accepted only when busy==0
//  op           in   3        MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5; 6/7 ignored
//  a            in   WIDTH    rs operand: multiplicand or dividend; the data for MTHI/MTLO
//  b            in   WIDTH    rt operand: multiplier or divisor
//  flush        in   1        abort the op in flight (branch or interrupt flush of EX)
//  busy         out  1        op in progress; core holds PC, IF/ID and ID/EX while high
//  done         out  1        one-cycle pulse when a MUL or DIV result is written to HI/LO
//  div_by_zero  out  1        sticky flag; set by DIV/DIVU with b==0, cleared by the next accepted start
//  hi           out  WIDTH    HI register
//  lo           out  WIDTH    LO register
//
// BEHAVIOUR
//  - Reset values:
//      - All outputs are 0, including hi and lo; state is IDLE.
//      - reset overrides every other input in the same cycle, including mid-operation.
//  - States: IDLE -> MUL | DIV -> FIX -> IDLE.
//  - IDLE:
//      - With start=1, op is MUL/DIV class and flush=0:
//          - latch |a|, |b| (MULTU/DIVU latch them raw) and the result sign;
//          - set busy the next cycle;
//          - load the iteration counter.
//      - MTHI/MTLO write hi/lo at the edge where start is sampled. They never raise busy or done.
//  - MUL:
//      - Radix-2 shift-add, one bit per cycle, WIDTH cycles.
//      - The product is 2*WIDTH bits; the upper half goes to HI and the lower half to LO.
//  - DIV:
//      - Restoring divide, one quotient bit per cycle, WIDTH cycles.
//  - FIX (1 cycle):
//      - Apply the sign correction.
//      - Write hi/lo.
//      - Pulse done.
//      - busy falls in the same cycle done is high.
//  - Latency from the start cycle to the done cycle is WIDTH+2 (34 at WIDTH=32).
//  - Signed rules:
//      - The quotient truncates toward zero.
//      - The remainder (HI) takes the sign of the dividend.
//      - The product is two's complement over 2*WIDTH bits.
//  - Boundary cases:
//      - b==0 on DIV/DIVU: skip the iteration; FIX writes hi=a, lo={WIDTH{1}}; set div_by_zero. Latency is 2.
//      - DIV with a = most-negative value and b = -1: lo = most-negative value, hi=0. No flag.
//      - start while busy: ignored. No queueing and no change to the op in flight.
//      - flush while busy: return to IDLE next cycle; hi/lo unchanged; no done.
//      - flush together with start in IDLE: start is ignored.
//      - flush in the FIX cycle: the result is still committed (the op has retired to HI/LO).
//      - MTHI/MTLO while busy: ignored. The pipeline stall guarantees they do not occur.
//      - The iteration counter is $clog2(WIDTH)+1 bits and does not wrap in operation.
//
// CONFIGURATION
//  MULDIV_FAST_MUL_EN
//  - Defined:
//      - MUL uses radix-4 Booth recoding, two bits per cycle, WIDTH/2 cycles.
//      - MUL latency is WIDTH/2+2 (18 at WIDTH=32).
//      - DIV is unchanged.
//  - Undefined:
//      - Radix-2 multiply as above.
//      - No Booth logic is synthesised.
//  - Results and flags are bit-identical in both builds; only the MUL latency differs.
//
// STRUCTURE
//  Package muldiv_pkg:
//  - MD_* op encodings.
//  - State encoding: ST_IDLE, ST_MUL, ST_DIV, ST_FIX.
//  - A helper function for the latency of a given op.
//  Sub-module muldiv_iter_core:
//  - Contains the shift/add/subtract datapath for one iteration.
//  - muldiv_unit keeps the FSM, counter, sign fix-up and HI/LO.
//
// TESTING  (WIDTH=32)
//  - MULTU a=FFFFFFFF, b=FFFFFFFF -> done at cycle 34; hi=FFFFFFFE, lo=00000001.
//  - MULT a=FFFFFFFD (-3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB.
//  - DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  - DIVU a=12345678, b=0 -> done at cycle 2; hi=12345678, lo=FFFFFFFF; div_by_zero=1.
//    The next start clears the flag.
//  - DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0.
//  - MTHI 0000AAAA, then MULT started with flush at cycle 10:
//      - busy drops at cycle 11;
//      - hi stays 0000AAAA;
//      - no done;
//      - a start while busy is ignored.
//  - Rerun the set with MULDIV_FAST_MUL_EN defined: results identical, MUL done at cycle 18.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Op/state encodings and latency helper shared by the multiply/divide unit.
// Latency depends on MULDIV_FAST_MUL_EN (radix-4 Booth multiply when defined).
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} md_state_e;

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Cycles from the start cycle to the done cycle, both counted; 0 for MTHI/MTLO.
    function automatic int unsigned md_latency(input logic [2:0] op, input int unsigned width,
                                               input logic b_zero);
        if (md_is_mul(op)) begin
`ifdef MULDIV_FAST_MUL_EN
            return width / 2 + 2;
`else
            return width + 2;
`endif
        end
        if (md_is_div(op)) return b_zero ? 2 : width + 2;
        return 0;
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the multiply (shift-add or radix-4 Booth) / restoring-divide datapath.
// Booth recoding is built only when MULDIV_FAST_MUL_EN is defined.
module muldiv_iter_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ACC_W = WIDTH
) (
    input  logic             is_div,
    input  logic [ACC_W-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] dvsr,
`ifdef MULDIV_FAST_MUL_EN
    input  logic             booth,
    output logic             booth_next,
`endif
    output logic [ACC_W-1:0] acc_next,
    output logic [WIDTH-1:0] shreg_next
);

    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    always_comb begin
        div_shift = {acc[WIDTH-1:0], shreg[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, dvsr};
        // Remainder always fits WIDTH bits once the subtract is taken.
        div_diff  = div_shift[WIDTH-1:0] - dvsr;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [ACC_W-1:0] mcand_ext;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;

    always_comb begin
        mcand_ext = {{(ACC_W-WIDTH){1'b0}}, dvsr};
        case ({shreg[1:0], booth})
            3'b001, 3'b010: addend = mcand_ext;
            3'b011:         addend = mcand_ext << 1;
            3'b100:         addend = -(mcand_ext << 1);
            3'b101, 3'b110: addend = -mcand_ext;
            default:        addend = '0;
        endcase
        sum = acc + addend;
    end
`else
    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, acc[WIDTH-1:0]} + (shreg[0] ? {1'b0, dvsr} : '0);
    end
`endif

    always_comb begin
        acc_next   = '0;
        shreg_next = '0;
`ifdef MULDIV_FAST_MUL_EN
        booth_next = 1'b0;
`endif
        if (is_div) begin
            if (div_ge) begin
                acc_next[WIDTH-1:0] = div_diff;
                shreg_next          = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next[WIDTH-1:0] = div_shift[WIDTH-1:0];
                shreg_next          = {shreg[WIDTH-2:0], 1'b0};
            end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            acc_next   = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
            shreg_next = {sum[1:0], shreg[WIDTH-1:2]};
            booth_next = shreg[1];
`else
            acc_next   = sum[WIDTH:1];
            shreg_next = {sum[0], shreg[WIDTH-1:1]};
`endif
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; FSM IDLE -> MUL|DIV -> FIX -> IDLE.
// Define MULDIV_FAST_MUL_EN for the radix-4 Booth multiply (WIDTH/2 iterations).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int unsigned ACC_W = WIDTH + 3;
`else
    localparam int unsigned ACC_W = WIDTH;
`endif

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_nxt;
    logic [WIDTH-1:0] shreg_q, shreg_d, shreg_nxt;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             neg_q, neg_d, rneg_q, rneg_d, is_div_q, is_div_d, dbz_q, dbz_d;
`ifdef MULDIV_FAST_MUL_EN
    logic             booth_q, booth_d, booth_nxt, mtop_q, mtop_d;
`endif

    muldiv_iter_core #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_core (
        .is_div     (state_q == ST_DIV),
        .acc        (acc_q),
        .shreg      (shreg_q),
        .dvsr       (dvsr_q),
`ifdef MULDIV_FAST_MUL_EN
        .booth      (booth_q),
        .booth_next (booth_nxt),
`endif
        .acc_next   (acc_nxt),
        .shreg_next (shreg_nxt)
    );

    logic             a_neg, b_neg, b_zero, accept;
    logic [WIDTH-1:0] a_mag, b_mag, mul_hi_raw, quo_fix, rem_fix, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        a_neg  = md_is_signed(op) & a[WIDTH-1];
        b_neg  = md_is_signed(op) & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        b_zero = (b == '0);
        // Ops 6/7 are not accepted; a start with flush never is.
        accept = start && !flush && (op <= MD_MTLO) &&
                 (state_q == ST_IDLE || state_q == ST_FIX);
    end

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        // Booth treats the multiplier as signed; add back mcand*2^WIDTH if its MSB was set.
        mul_hi_raw = acc_q[WIDTH-1:0] + (mtop_q ? dvsr_q : '0);
`else
        mul_hi_raw = acc_q;
`endif
        prod     = {mul_hi_raw, shreg_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -shreg_q : shreg_q;
        rem_fix  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        if (!is_div_q) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (dbz_q) begin
            fix_hi = shreg_q;
            fix_lo = '1;
        end else begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        shreg_d  = shreg_q;
        dvsr_d   = dvsr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        dbz_d    = dbz_q;
`ifdef MULDIV_FAST_MUL_EN
        booth_d  = booth_q;
        mtop_d   = mtop_q;
`endif
        case (state_q)
            ST_MUL, ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = acc_nxt;
                    shreg_d = shreg_nxt;
`ifdef MULDIV_FAST_MUL_EN
                    booth_d = booth_nxt;
`endif
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Commits even under flush: the op has already retired.
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            dbz_d = 1'b0;
            if (op == MD_MTHI) begin
                hi_d = a;
            end else if (op == MD_MTLO) begin
                lo_d = a;
            end else begin
                acc_d    = '0;
                neg_d    = a_neg ^ b_neg;
                rneg_d   = a_neg;
                is_div_d = md_is_div(op);
                cnt_d    = CNT_W'(md_latency(op, WIDTH, b_zero) - 2);
`ifdef MULDIV_FAST_MUL_EN
                booth_d  = 1'b0;
                mtop_d   = b_mag[WIDTH-1];
`endif
                if (md_is_mul(op)) begin
                    state_d = ST_MUL;
                    shreg_d = b_mag;
                    dvsr_d  = a_mag;
                end else begin
                    dbz_d   = b_zero;
                    state_d = b_zero ? ST_FIX : ST_DIV;
                    shreg_d = b_zero ? a : a_mag;
                    dvsr_d  = b_mag;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            shreg_q  <= '0;
            dvsr_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            booth_q  <= 1'b0;
            mtop_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            shreg_q  <= shreg_d;
            dvsr_q   <= dvsr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            dbz_q    <= dbz_d;
`ifdef MULDIV_FAST_MUL_EN
            booth_q  <= booth_d;
            mtop_q   <= mtop_d;
`endif
        end
    end

    assign busy        = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done        = (state_q == ST_FIX);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
